// File: rtl/sha256_spi_master_if.sv
// Local request/response port of sha256_spi_master: one register read or write per transaction.
interface sha256_spi_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/sha256_spi_master.sv
// SPI initiator for the sha256_spi register map: each request becomes one 16-bit write frame
// or a command frame plus a data frame for reads (SCK idles high, data changes on SCK fall).
module sha256_spi_master #(
  parameter int CLK_DIV    = 5,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2,
  parameter int GAP_CYCLES = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  sha256_spi_master_if.slave        bus,
  output logic                      o_sck,
  output logic                      o_ss_n,
  output logic                      o_mosi,
  input  logic                      i_miso
);

  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int MAX_WAIT = (SS_SETUP > SS_HOLD)
                            ? ((SS_SETUP > GAP_CYCLES) ? SS_SETUP : GAP_CYCLES)
                            : ((SS_HOLD > GAP_CYCLES) ? SS_HOLD : GAP_CYCLES);
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic             phase_q, phase_d;
  logic             sck_q, sck_d;
  logic             ss_n_q, ss_n_d;
  logic             mosi_q, mosi_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [15:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             wr_q;
  logic [6:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [15:0]      frame;
  logic             accept;

  function automatic logic [15:0] cmd_frame(input logic wr, input logic [6:0] addr,
                                            input logic [7:0] wdata);
    cmd_frame = {wr, addr, (wr ? wdata : 8'h00)};
  endfunction

  assign accept    = bus.req_valid && bus.req_ready;
  // The data frame of a read only clocks the slave; MOSI is held high throughout.
  assign frame     = phase_q ? 16'hFFFF : cmd_frame(wr_q, addr_q, wdata_q);

  assign bus.req_ready = (state_q == IDLE) && !i_rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = (state_q == SETUP) || (state_q == SHIFT) ||
                         (state_q == HOLD)  || (state_q == GAP);
  assign o_sck         = sck_q;
  assign o_ss_n        = ss_n_q;
  assign o_mosi        = mosi_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sck_d   = sck_q;
    ss_n_d  = ss_n_q;
    mosi_d  = mosi_q;
    rdata_d = rdata_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = SETUP;
          cnt_d   = '0;
          phase_d = 1'b0;
          ss_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SS_SETUP - 1)) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = 4'd0;
          sck_d   = 1'b0;
          mosi_d  = frame[15];
          tx_d    = {frame[14:0], 1'b1};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q != DIV_W'(CLK_DIV - 1)) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Last cycle of the high half-period: sample MISO, then fall or finish.
            rx_d = {rx_q[6:0], i_miso};
            if (bit_q == 4'd15) begin
              state_d = HOLD;
              cnt_d   = '0;
              mosi_d  = 1'b1;
            end else begin
              bit_d  = bit_q + 4'd1;
              sck_d  = 1'b0;
              mosi_d = tx_q[15];
              tx_d   = {tx_q[14:0], 1'b1};
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(SS_HOLD - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          ss_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          if (wr_q || phase_q) begin
            state_d = DONE;
            rdata_d = wr_q ? 8'h00 : rx_q;
          end else begin
            state_d = SETUP;
            cnt_d   = '0;
            phase_d = 1'b1;
            ss_n_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sck_d   = 1'b1;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b1;
      end
    endcase
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= 4'd0;
      phase_q     <= 1'b0;
      sck_q       <= 1'b1;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      sck_q       <= sck_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Request fields and shift registers carry data only and need no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      wr_q    <= bus.req_wr;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

endmodule

// File: tb/tb_sha256_spi_master.sv
// Directed bench for sha256_spi_master: frame contents, read data, latency, back-to-back and reset abort.
module tb_sha256_spi_master;

  localparam int F0 = 2 + 32 * 5 + 2 + 10;
  localparam int F1 = 1 + 32 * 2 + 1 + 1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  sha256_spi_master_if m0 ();
  sha256_spi_master_if m1 ();
  logic o_sck0, o_ss_n0, o_mosi0, miso0;
  logic o_sck1, o_ss_n1, o_mosi1;
  logic miso1 = 1'b0;

  sha256_spi_master dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .bus(m0),
    .o_sck(o_sck0), .o_ss_n(o_ss_n0), .o_mosi(o_mosi0), .i_miso(miso0)
  );

  sha256_spi_master #(.CLK_DIV(2), .SS_SETUP(1), .SS_HOLD(1), .GAP_CYCLES(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .bus(m1),
    .o_sck(o_sck1), .o_ss_n(o_ss_n1), .o_mosi(o_mosi1), .i_miso(miso1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Slave-side model for dut0: capture MOSI on SCK rise, present MISO on SCK fall.
  logic [15:0] cap0, miso_word, miso_w0, miso_w1;
  logic        miso_sel;
  int          bits0, hi_run, last_gap;
  logic [15:0] frames0[$];
  int          fbits0[$];

  initial begin
    miso0 = 1'b1; miso_sel = 1'b0; miso_w0 = 16'h0; miso_w1 = 16'h0;
    miso_word = 16'h0; cap0 = 16'h0; bits0 = 0; hi_run = 0; last_gap = 0;
  end

  always @(negedge o_ss_n0) begin
    cap0 = 16'h0;
    bits0 = 0;
    miso_word = miso_sel ? miso_w1 : miso_w0;
    miso_sel = ~miso_sel;
  end
  always @(posedge o_sck0) if (o_ss_n0 === 1'b0) begin
    cap0 = {cap0[14:0], o_mosi0};
    bits0++;
  end
  always @(negedge o_sck0) if (o_ss_n0 === 1'b0) begin
    miso0 = miso_word[15];
    miso_word = {miso_word[14:0], 1'b0};
  end
  always @(posedge o_ss_n0) begin
    frames0.push_back(cap0);
    fbits0.push_back(bits0);
  end
  always @(posedge i_clk) begin
    if (o_ss_n0 === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      last_gap = hi_run;
      hi_run = 0;
    end
  end

  // Monitor for dut1: MOSI capture and SCK period in clock cycles.
  logic [15:0] cap1;
  logic [15:0] frames1[$];
  int          cyc = 0;
  int          last_rise1 = -1;
  int          per1 = 0;
  always @(posedge i_clk) cyc++;
  always @(negedge o_ss_n1) begin
    cap1 = 16'h0;
    last_rise1 = -1;
  end
  always @(posedge o_sck1) if (o_ss_n1 === 1'b0) begin
    cap1 = {cap1[14:0], o_mosi1};
    if (last_rise1 >= 0) per1 = cyc - last_rise1;
    last_rise1 = cyc;
  end
  always @(posedge o_ss_n1) frames1.push_back(cap1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on dut0; inputs are scrambled after acceptance. lat = -1 on timeout.
  task automatic req0(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                      output logic [7:0] rdata, output int lat, output logic busy1);
    @(negedge i_clk);
    m0.req_valid = 1'b1; m0.req_wr = wr; m0.req_addr = addr; m0.req_wdata = wdata;
    for (int g = 0; g < 1000 && m0.req_ready !== 1'b1; g++) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    m0.req_valid = 1'b0; m0.req_wr = ~wr; m0.req_addr = ~addr; m0.req_wdata = ~wdata;
    lat = -1; rdata = 8'hxx; busy1 = 1'bx;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge i_clk);
      if (c == 1) busy1 = m0.busy;
      if (m0.rsp_valid === 1'b1) begin
        lat = c;
        rdata = m0.rsp_rdata;
        break;
      end
    end
  endtask

  logic [7:0] rd;
  int         lat, t_rsp, t_acc;
  logic       busy1, early_ready, saw_rsp;

  initial begin
    m0.req_valid = 1'b0; m0.req_wr = 1'b0; m0.req_addr = 7'h0; m0.req_wdata = 8'h0;
    m1.req_valid = 1'b0; m1.req_wr = 1'b0; m1.req_addr = 7'h0; m1.req_wdata = 8'h0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_sck",   {31'h0, o_sck0},      32'h1);
    check("rst_ss_n",  {31'h0, o_ss_n0},     32'h1);
    check("rst_mosi",  {31'h0, o_mosi0},     32'h1);
    check("rst_rsp",   {31'h0, m0.rsp_valid}, 32'h0);
    check("rst_rdata", {24'h0, m0.rsp_rdata}, 32'h0);
    check("rst_busy",  {31'h0, m0.busy},      32'h0);
    check("rst_ready", {31'h0, m0.req_ready}, 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst", {31'h0, m0.req_ready}, 32'h1);
    frames0.delete(); fbits0.delete(); frames1.delete();

    // Write 0x05 <- 0x3C
    req0(1'b1, 7'h05, 8'h3C, rd, lat, busy1);
    check("wr_lat",    lat, F0 + 1);
    check("wr_rdata",  {24'h0, rd}, 32'h0);
    check("wr_busy",   {31'h0, busy1}, 32'h1);
    check("wr_nframe", frames0.size(), 1);
    check("wr_frame",  {16'h0, frames0[0]}, 32'h853C);
    check("wr_bits",   fbits0[0], 16);
    @(negedge i_clk);
    check("wr_ready_after", {31'h0, m0.req_ready}, 32'h1);
    check("wr_busy_after",  {31'h0, m0.busy}, 32'h0);

    // Read 0x12, slave returns 0xA5 in the data frame
    frames0.delete(); fbits0.delete();
    miso_w0 = 16'h3C3C; miso_w1 = 16'h00A5; miso_sel = 1'b0;
    req0(1'b0, 7'h12, 8'h77, rd, lat, busy1);
    check("rd_lat",    lat, 2 * F0 + 1);
    check("rd_rdata",  {24'h0, rd}, 32'hA5);
    check("rd_nframe", frames0.size(), 2);
    check("rd_cmd",    {16'h0, frames0[0]}, 32'h1200);
    check("rd_data",   {16'h0, frames0[1]}, 32'hFFFF);
    check("rd_gap",    last_gap, 10);

    // Back-to-back writes with valid held high
    frames0.delete(); fbits0.delete();
    @(negedge i_clk);
    m0.req_valid = 1'b1; m0.req_wr = 1'b1; m0.req_addr = 7'h40; m0.req_wdata = 8'h11;
    for (int g = 0; g < 1000 && m0.req_ready !== 1'b1; g++) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    m0.req_wdata = 8'h22;
    t_rsp = -1; t_acc = -1; early_ready = 1'b0; rd = 8'hxx;
    for (int c = 1; c <= 1000 && t_acc < 0; c++) begin
      @(negedge i_clk);
      if (m0.rsp_valid === 1'b1 && t_rsp < 0) begin
        t_rsp = c;
        rd = m0.rsp_rdata;
      end else if (m0.req_ready === 1'b1) begin
        if (t_rsp < 0) early_ready = 1'b1;
        else t_acc = c;
      end
    end
    @(posedge i_clk);
    #1;
    m0.req_valid = 1'b0;
    check("b2b_early_ready", {31'h0, early_ready}, 32'h0);
    check("b2b_first_lat",   t_rsp, F0 + 1);
    check("b2b_accept_gap",  t_acc - t_rsp, 1);
    check("b2b_rdata1",      {24'h0, rd}, 32'h0);
    lat = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge i_clk);
      if (m0.rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("b2b_second_lat", lat, F0 + 1);
    check("b2b_nframe",     frames0.size(), 2);
    check("b2b_frame1",     {16'h0, frames0[0]}, 32'hC011);
    check("b2b_frame2",     {16'h0, frames0[1]}, 32'hC022);
    check("b2b_gap_min",    {31'h0, (last_gap >= 10)}, 32'h1);

    // Reset pulse at bit 7 of a write aborts the frame
    bits0 = 0;
    @(negedge i_clk);
    m0.req_valid = 1'b1; m0.req_wr = 1'b1; m0.req_addr = 7'h2A; m0.req_wdata = 8'h5A;
    for (int g = 0; g < 1000 && m0.req_ready !== 1'b1; g++) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    m0.req_valid = 1'b0;
    for (int g = 0; g < 2000 && bits0 < 7; g++) @(negedge i_clk);
    check("abort_reached_bit7", bits0, 7);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("abort_ss_n",  {31'h0, o_ss_n0},      32'h1);
    check("abort_sck",   {31'h0, o_sck0},       32'h1);
    check("abort_mosi",  {31'h0, o_mosi0},      32'h1);
    check("abort_rsp",   {31'h0, m0.rsp_valid}, 32'h0);
    check("abort_busy",  {31'h0, m0.busy},      32'h0);
    check("abort_ready", {31'h0, m0.req_ready}, 32'h0);
    i_rst = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < F0 + 20; c++) begin
      @(negedge i_clk);
      if (m0.rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    check("abort_no_rsp", {31'h0, saw_rsp}, 32'h0);

    // Next request after the abort completes normally
    frames0.delete(); fbits0.delete();
    req0(1'b1, 7'h00, 8'hFF, rd, lat, busy1);
    check("post_lat",   lat, F0 + 1);
    check("post_frame", {16'h0, frames0[0]}, 32'h80FF);
    check("post_bits",  fbits0[0], 16);

    // Minimum timing instance: CLK_DIV=2, setup/hold/gap of one cycle
    frames1.delete();
    @(negedge i_clk);
    m1.req_valid = 1'b1; m1.req_wr = 1'b1; m1.req_addr = 7'h55; m1.req_wdata = 8'hC3;
    for (int g = 0; g < 1000 && m1.req_ready !== 1'b1; g++) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    m1.req_valid = 1'b0; m1.req_addr = 7'h00; m1.req_wdata = 8'h00;
    lat = -1; rd = 8'hxx;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge i_clk);
      if (m1.rsp_valid === 1'b1) begin
        lat = c;
        rd = m1.rsp_rdata;
        break;
      end
    end
    check("fast_lat",    lat, F1 + 1);
    check("fast_rdata",  {24'h0, rd}, 32'h0);
    check("fast_nframe", frames1.size(), 1);
    check("fast_frame",  {16'h0, frames1[0]}, 32'hD5C3);
    check("fast_sck_period", per1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
